// File: rtl/frame_io_ctrl.sv
// Frame harness: streams the source frame to the core, then captures its addressed output
// into the destination RAM while checking it against the golden RAM and tallying errors.
module frame_io_ctrl #(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 2000,
  parameter int TOL     = 1,
  parameter int CNT_W   = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic [PIX_W-1:0]  in_data,
  input  logic              out_valid,
  input  logic [ADDR_W-1:0] out_addr,
  input  logic [PIX_W-1:0]  out_data,
  input  logic              finish,
  output logic [ADDR_W-1:0] src_rd_addr,
  input  logic [PIX_W-1:0]  src_rd_data,
  output logic [ADDR_W-1:0] gold_rd_addr,
  input  logic [PIX_W-1:0]  gold_rd_data,
  output logic              dst_wr_en,
  output logic [ADDR_W-1:0] dst_wr_addr,
  output logic [PIX_W-1:0]  dst_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_proto,
  output logic [CNT_W-1:0]  pix_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  err_loose_cnt,
  output logic [CNT_W-1:0]  latency
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int LD_W = $clog2(NPIX + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int DW   = PIX_W + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_COLLECT = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]        state;
  logic [LD_W-1:0]   ld_cnt;
  logic [WD_W-1:0]   wdog;
  logic              drain_2nd;
  logic              ld_q;

  logic              s1_vld;
  logic [ADDR_W-1:0] s1_addr;
  logic [PIX_W-1:0]  s1_dat;
  logic              s2_vld;
  logic [PIX_W-1:0]  s2_dat;

  logic              start_ok;
  logic              in_loop;
  logic              beat;
  logic              last_beat;
  logic              early_fin;
  logic              wd_expired;
  logic [DW-1:0]     diff;
  logic [DW-1:0]     adiff;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    start_ok   = start && (state == S_IDLE || state == S_DONE);
    in_loop    = (state == S_WAIT) || (state == S_COLLECT);
    beat       = in_loop && out_valid;
    last_beat  = beat && (pix_cnt == CNT_W'(NPIX - 1));
    early_fin  = (state == S_COLLECT) && finish && !last_beat;
    wd_expired = in_loop && !out_valid && (wdog == WD_W'(TIMEOUT - 1));
    // Both operands zero-extended so the subtraction is a true signed difference.
    diff       = {1'b0, s2_dat} - {1'b0, gold_rd_data};
    adiff      = diff[PIX_W] ? (~diff + DW'(1)) : diff;
  end

  assign in_valid     = (state == S_LOAD);
  assign src_rd_addr  = in_valid ? in_addr : '0;
  assign in_data      = ld_q ? src_rd_data : '0;
  assign gold_rd_addr = s1_addr;
  assign dst_wr_en    = s1_vld;
  assign dst_wr_addr  = s1_addr;
  assign dst_wr_data  = s1_dat;
  assign busy         = (state == S_LOAD) || (state == S_WAIT) ||
                        (state == S_COLLECT) || (state == S_DRAIN);
  assign done         = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ld_cnt      <= '0;
      wdog        <= '0;
      drain_2nd   <= 1'b0;
      ld_q        <= 1'b0;
      err_timeout <= 1'b0;
      err_proto   <= 1'b0;
    end else begin
      ld_q      <= (state == S_LOAD);
      drain_2nd <= (state == S_DRAIN);
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state       <= S_LOAD;
            ld_cnt      <= '0;
            wdog        <= '0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (out_valid) err_proto <= 1'b1;
          if (ld_cnt == LD_W'(NPIX - 1)) begin
            state <= S_WAIT;
            wdog  <= '0;
          end else begin
            ld_cnt <= ld_cnt + LD_W'(1);
          end
        end
        S_WAIT, S_COLLECT: begin
          if (last_beat) begin
            state <= S_DRAIN;
          end else if (early_fin) begin
            err_proto <= 1'b1;
            state     <= S_DRAIN;
          end else if (beat) begin
            wdog  <= '0;
            state <= S_COLLECT;
          end else if (wd_expired) begin
            err_timeout <= 1'b1;
            state       <= S_DONE;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_2nd) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld        <= 1'b0;
      s1_addr       <= '0;
      s1_dat        <= '0;
      s2_vld        <= 1'b0;
      s2_dat        <= '0;
      pix_cnt       <= '0;
      err_cnt       <= '0;
      err_loose_cnt <= '0;
      latency       <= '0;
    end else begin
      s1_vld <= beat;
      if (beat) begin
        s1_addr <= out_addr;
        s1_dat  <= out_data;
      end
      s2_vld <= s1_vld;
      s2_dat <= s1_dat;
      if (start_ok) begin
        pix_cnt       <= '0;
        err_cnt       <= '0;
        err_loose_cnt <= '0;
        latency       <= '0;
      end else begin
        if (beat) pix_cnt <= sat_inc(pix_cnt);
        // Latency stops counting on the first output beat seen in WAIT.
        if (state == S_LOAD || (state == S_WAIT && !out_valid)) latency <= sat_inc(latency);
        if (s2_vld && diff != '0) err_cnt <= sat_inc(err_cnt);
        if (s2_vld && adiff > DW'(TOL)) err_loose_cnt <= sat_inc(err_loose_cnt);
      end
    end
  end

endmodule

// File: tb/tb_frame_io_ctrl.sv
// Bench for frame_io_ctrl on an 8x8 frame: table of frame scenarios plus reset sequences.
module tb_frame_io_ctrl;
  localparam int IMG_W   = 8;
  localparam int IMG_H   = 8;
  localparam int PIX_W   = 10;
  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 40;
  localparam int TOL     = 1;
  localparam int CNT_W   = 17;
  localparam int NPIX    = IMG_W * IMG_H;
  localparam int BUDGET  = 400;
  localparam int NVEC    = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [PIX_W-1:0]  in_data;
  logic              out_valid = 1'b0;
  logic [ADDR_W-1:0] out_addr = '0;
  logic [PIX_W-1:0]  out_data = '0;
  logic              finish = 1'b0;
  logic [ADDR_W-1:0] src_rd_addr;
  logic [PIX_W-1:0]  src_rd_data;
  logic [ADDR_W-1:0] gold_rd_addr;
  logic [PIX_W-1:0]  gold_rd_data;
  logic              dst_wr_en;
  logic [ADDR_W-1:0] dst_wr_addr;
  logic [PIX_W-1:0]  dst_wr_data;
  logic              busy;
  logic              done;
  logic              err_timeout;
  logic              err_proto;
  logic [CNT_W-1:0]  pix_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  err_loose_cnt;
  logic [CNT_W-1:0]  latency;

  frame_io_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W),
    .TIMEOUT(TIMEOUT), .TOL(TOL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data), .finish(finish),
    .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .gold_rd_addr(gold_rd_addr), .gold_rd_data(gold_rd_data),
    .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_proto(err_proto),
    .pix_cnt(pix_cnt), .err_cnt(err_cnt), .err_loose_cnt(err_loose_cnt), .latency(latency)
  );

  always #5 clk = ~clk;

  logic [PIX_W-1:0] src_mem  [NPIX];
  logic [PIX_W-1:0] gold_mem [NPIX];
  logic [PIX_W-1:0] dst_mem  [NPIX];
  logic [PIX_W-1:0] cap      [NPIX];
  logic [PIX_W-1:0] exp_dst  [NPIX];

  always @(posedge clk) begin
    src_rd_data  <= src_mem[src_rd_addr];
    gold_rd_data <= gold_mem[gold_rd_addr];
    if (dst_wr_en) dst_mem[dst_wr_addr] <= dst_wr_data;
  end

  typedef struct {
    int gap0; int nbeats; int gap; int pulse_at; int start_at; int rst_beat; int fin; int mode;
    int e_pix; int e_err; int e_loose; int e_proto; int e_tmo; int e_lat; int e_done;
  } vec_t;

  vec_t tbl [NVEC];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc, done_cyc, nvalid, bad_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int delta(input int mode, input int i);
    if (mode != 1) return 0;
    if (i < 10) return 1;
    if (i == 20 || i == 21) return 3;
    if (i == 40) return -2;
    if (i == 41) return -1;
    return 0;
  endfunction

  task automatic step();
    if (in_valid) nvalid++;
    if (done && done_cyc < 0) done_cyc = cyc;
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_frame(input vec_t v, output bit aborted);
    aborted = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; done_cyc = -1; nvalid = 0; bad_in = 0;
    for (int k = 0; k <= NPIX; k++) begin
      if (k >= 1) begin
        cap[k-1] = in_data;
        if (in_data !== src_mem[k-1]) bad_in++;
      end
      out_valid = (k == v.pulse_at);
      start     = (k == v.start_at);
      in_addr   = (k < NPIX) ? ADDR_W'(k) : '0;
      step();
    end
    out_valid = 1'b0;
    start     = 1'b0;
    if (v.nbeats > 0) begin
      repeat (v.gap0 - 1) step();
      for (int i = 0; i < v.nbeats; i++) begin
        out_valid  = 1'b1;
        out_addr   = ADDR_W'(i);
        out_data   = PIX_W'(int'(cap[i]) + delta(v.mode, i));
        exp_dst[i] = out_data;
        if (i == v.rst_beat) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          out_valid = 1'b0;
          aborted = 1'b1;
          return;
        end
        step();
        out_valid = 1'b0;
        for (int j = 0; j < v.gap; j++) begin
          finish = (v.fin != 0) && (i == v.nbeats - 1) && (j == 0);
          step();
          finish = 1'b0;
        end
      end
    end
    while (done_cyc < 0 && cyc < BUDGET) step();
  endtask

  task automatic check_results(input vec_t v, input int n);
    int bad_dst;
    bad_dst = 0;
    for (int i = 0; i < v.nbeats; i++) if (dst_mem[i] !== exp_dst[i]) bad_dst++;
    check($sformatf("v%0d_done_cycle", n), done_cyc, v.e_done);
    check($sformatf("v%0d_pix_cnt", n), pix_cnt, v.e_pix);
    check($sformatf("v%0d_err_cnt", n), err_cnt, v.e_err);
    check($sformatf("v%0d_err_loose_cnt", n), err_loose_cnt, v.e_loose);
    check($sformatf("v%0d_err_proto", n), err_proto, v.e_proto);
    check($sformatf("v%0d_err_timeout", n), err_timeout, v.e_tmo);
    check($sformatf("v%0d_latency", n), latency, v.e_lat);
    check($sformatf("v%0d_in_valid_cycles", n), nvalid, NPIX);
    check($sformatf("v%0d_in_data_errors", n), bad_in, 0);
    check($sformatf("v%0d_dst_errors", n), bad_dst, 0);
    check($sformatf("v%0d_busy_at_end", n), busy, 0);
    check($sformatf("v%0d_done_at_end", n), done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    vec_t v;
    bit   ab;
    //        gap0 nb gap pulse st  rst fin mode  pix err loose proto tmo lat done
    tbl[0] = '{5, 64, 0, -1, -1, -1, 0, 0,   64, 0,  0, 0, 0,  69, 135};
    tbl[1] = '{3, 64, 1, -1, -1, -1, 0, 1,   64, 14, 3, 0, 0,  67, 196};
    tbl[2] = '{5, 0,  0, -1, -1, -1, 0, 0,   0,  0,  0, 0, 1, 104, 104};
    tbl[3] = '{5, 64, 0, 10, 30, -1, 0, 0,   64, 0,  0, 1, 0,  69, 135};
    tbl[4] = '{5, 12, 3, -1, -1, -1, 1, 0,   12, 0,  0, 1, 0,  69, 117};
    tbl[5] = '{5, 5,  0, -1, -1, -1, 0, 0,   5,  0,  0, 0, 1,  69, 114};
    tbl[6] = '{5, 64, 0, -1, -1, -1, 0, 0,   64, 0,  0, 0, 0,  69, 135};
    for (int i = 0; i < NPIX; i++) begin
      src_mem[i]  = PIX_W'((i * 7 + 3) % 1024);
      gold_mem[i] = src_mem[i];
    end

    // Reset held with start, a beat and an address all active: reset must win.
    rst = 1'b1; start = 1'b1; out_valid = 1'b1; in_addr = 6'd5;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_err_proto", err_proto, 0);
    check("rst_pix_cnt", pix_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_err_loose_cnt", err_loose_cnt, 0);
    check("rst_latency", latency, 0);
    check("rst_dst_wr_en", dst_wr_en, 0);
    check("rst_in_valid", in_valid, 0);
    check("rst_src_rd_addr", src_rd_addr, 0);
    check("rst_in_data", in_data, 0);
    rst = 1'b0; start = 1'b0; out_valid = 1'b0; in_addr = '0;
    @(negedge clk);
    check("post_rst_idle_busy", busy, 0);

    for (int n = 0; n < NVEC; n++) begin
      run_frame(tbl[n], ab);
      check_results(tbl[n], n);
    end

    // Reset in the middle of collection, then a clean frame.
    v = tbl[1];
    v.rst_beat = 30;
    run_frame(v, ab);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_pix_cnt", pix_cnt, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_latency", latency, 0);
    check("midrst_dst_wr_en", dst_wr_en, 0);
    check("midrst_gold_rd_addr", gold_rd_addr, 0);
    @(negedge clk);
    check("midrst_stays_idle", {busy, done}, 0);
    run_frame(tbl[0], ab);
    check_results(tbl[0], 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
